// File: rtl/card_dealer_regs.sv
// Card source and six-slot hand register bank with mod-10 hand scores for the baccarat datapath.
// Optional build macro DEAL_FORCE_EN adds force_en/force_card to deal a chosen card instead of the counter.
module card_dealer_regs #(
  parameter int CARD_MAX  = 13,
  parameter int NUM_SLOTS = 6
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       clear_hands,
  input  logic       deal_req,
  input  logic [2:0] slot,
`ifdef DEAL_FORCE_EN
  input  logic       force_en,
  input  logic [3:0] force_card,
`endif
  output logic       deal_busy,
  output logic       deal_done,
  output logic       slot_err,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] CARD_TOP   = 4'(CARD_MAX);
  localparam logic [3:0] SLOT_LIMIT = 4'(NUM_SLOTS);

  logic [1:0] state;
  logic [3:0] card_cnt;
  logic [3:0] cap_card;
  logic [2:0] cap_slot;
  logic [3:0] sel_card;
  logic [3:0] hand [NUM_SLOTS];

  // Free-running card source; never passes through 0 so every deal is a real card.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      card_cnt <= 4'd1;
    end else if (card_cnt >= CARD_TOP) begin
      card_cnt <= 4'd1;
    end else begin
      card_cnt <= card_cnt + 4'd1;
    end
  end

`ifdef DEAL_FORCE_EN
  // Out-of-range forced codes become a blank card so the decoders never see 14/15.
  always_comb begin
    sel_card = card_cnt;
    if (force_en) begin
      sel_card = (force_card > CARD_TOP) ? 4'd0 : force_card;
    end
  end
`else
  assign sel_card = card_cnt;
`endif

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state    <= ST_IDLE;
      cap_card <= 4'd0;
      cap_slot <= 3'd0;
    end else if (clear_hands) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (deal_req) begin
            cap_card <= sel_card;
            cap_slot <= slot;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Illegal slot codes match no entry, so the handshake completes without a write.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_SLOTS; i++) hand[i] <= 4'd0;
    end else if (clear_hands) begin
      for (int i = 0; i < NUM_SLOTS; i++) hand[i] <= 4'd0;
    end else if (state == ST_LOAD) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cap_slot == 3'(i)) hand[i] <= cap_card;
      end
    end
  end

  assign deal_busy = (state != ST_IDLE);
  assign deal_done = (state == ST_DONE);
  assign slot_err  = (state == ST_DONE) && ({1'b0, cap_slot} >= SLOT_LIMIT);

  assign pcard1 = hand[0];
  assign pcard2 = hand[1];
  assign pcard3 = hand[2];
  assign dcard1 = hand[3];
  assign dcard2 = hand[4];
  assign dcard3 = hand[5];

  function automatic logic [4:0] card_val(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? {1'b0, c} : 5'd0;
  endfunction

  // Three-card sum is at most 27, so two conditional subtractions finish the mod 10.
  function automatic logic [3:0] mod10(input logic [4:0] s);
    logic [4:0] r;
    r = s;
    if (r >= 5'd20)      r = r - 5'd20;
    else if (r >= 5'd10) r = r - 5'd10;
    return r[3:0];
  endfunction

  assign pscore = mod10(card_val(hand[0]) + card_val(hand[1]) + card_val(hand[2]));
  assign dscore = mod10(card_val(hand[3]) + card_val(hand[4]) + card_val(hand[5]));

endmodule

// File: tb/tb_card_dealer_regs.sv
// Self-checking bench for card_dealer_regs: randomized deals against a hand/score reference model.
module tb_card_dealer_regs;

  logic       slow_clock = 1'b0;
  logic       resetb;
  logic       clear_hands;
  logic       deal_req;
  logic [2:0] slot;
`ifdef DEAL_FORCE_EN
  logic       force_en;
  logic [3:0] force_card;
`endif
  logic       deal_busy, deal_done, slot_err;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;

  int compared   = 0;
  int mismatched = 0;
  int tb_edges;
  int model_hand [6];

  card_dealer_regs dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .clear_hands(clear_hands),
    .deal_req   (deal_req),
    .slot       (slot),
`ifdef DEAL_FORCE_EN
    .force_en   (force_en),
    .force_card (force_card),
`endif
    .deal_busy  (deal_busy),
    .deal_done  (deal_done),
    .slot_err   (slot_err),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pscore     (pscore),
    .dscore     (dscore)
  );

  always #5 slow_clock = ~slow_clock;

  // Edges since reset release; the card seen at an edge is (edges before it mod 13) + 1.
  always @(posedge slow_clock or negedge resetb) begin
    if (!resetb) tb_edges <= 0;
    else         tb_edges <= tb_edges + 1;
  end

  function automatic int card_value(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int model_score(input int base);
    return (card_value(model_hand[base]) + card_value(model_hand[base+1]) +
            card_value(model_hand[base+2])) % 10;
  endfunction

  function automatic int dut_slot(input int i);
    case (i)
      0: return int'(pcard1);
      1: return int'(pcard2);
      2: return int'(pcard3);
      3: return int'(dcard1);
      4: return int'(dcard2);
      default: return int'(dcard3);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge slow_clock);
    resetb = 1'b0;
    clear_hands = 1'b0;
    deal_req = 1'b0;
    slot = 3'd0;
    @(negedge slow_clock);
    resetb = 1'b1;
    for (int i = 0; i < 6; i++) model_hand[i] = 0;
  endtask

  // Issues one request from IDLE at a falling edge and returns once the DUT is back in IDLE.
  task automatic run_deal(input int s, output int exp_card, output int latency, output logic err_seen);
    exp_card = (tb_edges % 13) + 1;
`ifdef DEAL_FORCE_EN
    if (force_en) exp_card = (force_card > 4'd13) ? 0 : int'(force_card);
`endif
    deal_req = 1'b1;
    slot = 3'(s);
    @(posedge slow_clock);
    #1 deal_req = 1'b0;
    latency = 0;
    err_seen = 1'b0;
    do begin
      @(negedge slow_clock);
      latency++;
    end while (!deal_done && latency < 8);
    if (deal_done) err_seen = slot_err;
    @(negedge slow_clock);
    if (s < 6) model_hand[s] = exp_card;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    clear_hands = 1'b0;
    deal_req = 1'b0;
    slot = 3'd0;
`ifdef DEAL_FORCE_EN
    force_en = 1'b0;
    force_card = 4'd0;
`endif
    for (int i = 0; i < 6; i++) model_hand[i] = 0;
    @(negedge slow_clock);
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (dut_slot(i) !== 0) begin
        mismatched++;
        $display("[TB] FAIL reset_slot%0d: got %0d expected 0", i, dut_slot(i));
      end
    end
    compared++;
    if ({deal_busy, deal_done, slot_err} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got busy/done/err=%b expected 000", {deal_busy, deal_done, slot_err});
    end
    compared++;
    if (pscore !== 4'd0 || dscore !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_scores: got p=%0d d=%0d expected 0/0", pscore, dscore);
    end
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  task automatic test_counter();
    int ec, lat;
    logic err;
    for (int i = 0; i < 20; i++) begin
      do_reset();
      repeat (i) @(negedge slow_clock);
      run_deal(0, ec, lat, err);
      compared++;
      if (int'(pcard1) !== (i % 13) + 1) begin
        mismatched++;
        $display("[TB] FAIL counter_capture%0d: got %0d expected %0d", i, pcard1, (i % 13) + 1);
      end
    end
  endtask

  task automatic test_random_deals();
    int ec, lat, s;
    logic err;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge slow_clock);
      s = $urandom_range(0, 7);
      run_deal(s, ec, lat, err);
      compared++;
      if (lat !== 2) begin
        mismatched++;
        $display("[TB] FAIL rand_latency%0d: got %0d cycles expected 2", n, lat);
      end
      compared++;
      if (err !== (s >= 6)) begin
        mismatched++;
        $display("[TB] FAIL rand_slot_err%0d: got %b expected %b (slot %0d)", n, err, (s >= 6), s);
      end
      for (int i = 0; i < 6; i++) begin
        compared++;
        if (dut_slot(i) !== model_hand[i]) begin
          mismatched++;
          $display("[TB] FAIL rand_slot%0d_deal%0d: got %0d expected %0d", i, n, dut_slot(i), model_hand[i]);
        end
      end
      compared++;
      if (int'(pscore) !== model_score(0) || int'(dscore) !== model_score(3)) begin
        mismatched++;
        $display("[TB] FAIL rand_scores%0d: got p=%0d d=%0d expected %0d/%0d",
                 n, pscore, dscore, model_score(0), model_score(3));
      end
    end
  endtask

  task automatic test_illegal_slot();
    int ec, lat;
    logic err;
    for (int s = 6; s < 8; s++) begin
      run_deal(s, ec, lat, err);
      compared++;
      if (err !== 1'b1 || lat !== 2) begin
        mismatched++;
        $display("[TB] FAIL illegal_handshake%0d: got err=%b latency=%0d expected err=1 latency=2", s, err, lat);
      end
      for (int i = 0; i < 6; i++) begin
        compared++;
        if (dut_slot(i) !== model_hand[i]) begin
          mismatched++;
          $display("[TB] FAIL illegal_slot%0d_touched%0d: got %0d expected %0d", s, i, dut_slot(i), model_hand[i]);
        end
      end
    end
  endtask

  task automatic test_clear_hands();
    int ec, lat, done_seen;
    logic err;
    run_deal(0, ec, lat, err);
    run_deal(5, ec, lat, err);
    deal_req = 1'b1;
    slot = 3'd2;
    @(posedge slow_clock);
    #1 deal_req = 1'b0;
    @(negedge slow_clock);
    compared++;
    if (deal_busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL clear_pre_busy: got %b expected 1", deal_busy);
    end
    clear_hands = 1'b1;
    @(posedge slow_clock);
    #1 clear_hands = 1'b0;
    for (int i = 0; i < 6; i++) model_hand[i] = 0;
    @(negedge slow_clock);
    compared++;
    if (deal_busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL clear_busy: got %b expected 0", deal_busy);
    end
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (dut_slot(i) !== 0) begin
        mismatched++;
        $display("[TB] FAIL clear_slot%0d: got %0d expected 0", i, dut_slot(i));
      end
    end
    done_seen = 0;
    repeat (4) begin
      if (deal_done) done_seen++;
      @(negedge slow_clock);
    end
    compared++;
    if (done_seen !== 0) begin
      mismatched++;
      $display("[TB] FAIL clear_no_done: got %0d pulses expected 0", done_seen);
    end
    run_deal(0, ec, lat, err);
    clear_hands = 1'b1;
    deal_req = 1'b1;
    slot = 3'd1;
    @(posedge slow_clock);
    #1 begin
      clear_hands = 1'b0;
      deal_req = 1'b0;
    end
    model_hand[0] = 0;
    @(negedge slow_clock);
    compared++;
    if (deal_busy !== 1'b0 || pcard1 !== 4'd0 || pcard2 !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL clear_vs_req: got busy=%b p1=%0d p2=%0d expected 0/0/0", deal_busy, pcard1, pcard2);
    end
  endtask

  task automatic test_back_to_back();
    int t0, pulses, exp_card;
    @(negedge slow_clock);
    t0 = tb_edges;
    pulses = 0;
    deal_req = 1'b1;
    slot = 3'd4;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge slow_clock);
      if (cyc == 9) deal_req = 1'b0;
      if (deal_done) pulses++;
    end
    exp_card = ((t0 + 6) % 13) + 1;
    model_hand[4] = exp_card;
    compared++;
    if (pulses !== 3) begin
      mismatched++;
      $display("[TB] FAIL b2b_pulses: got %0d expected 3", pulses);
    end
    compared++;
    if (int'(dcard2) !== exp_card) begin
      mismatched++;
      $display("[TB] FAIL b2b_last_card: got %0d expected %0d", dcard2, exp_card);
    end
    compared++;
    if (int'(dscore) !== model_score(3)) begin
      mismatched++;
      $display("[TB] FAIL b2b_dscore: got %0d expected %0d", dscore, model_score(3));
    end
  endtask

  task automatic test_async_reset();
    deal_req = 1'b1;
    slot = 3'd1;
    @(posedge slow_clock);
    #1 deal_req = 1'b0;
    #2 resetb = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (dut_slot(i) !== 0) begin
        mismatched++;
        $display("[TB] FAIL async_slot%0d: got %0d expected 0", i, dut_slot(i));
      end
    end
    compared++;
    if (deal_busy !== 1'b0 || deal_done !== 1'b0 || pscore !== 4'd0 || dscore !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL async_state: got busy=%b done=%b p=%0d d=%0d expected 0", deal_busy, deal_done, pscore, dscore);
    end
    @(negedge slow_clock);
    resetb = 1'b1;
    for (int i = 0; i < 6; i++) model_hand[i] = 0;
  endtask

`ifdef DEAL_FORCE_EN
  task automatic test_force();
    int ec, lat;
    logic err;
    int fc [6] = '{9, 7, 15, 12, 10, 13};
    do_reset();
    force_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      force_card = 4'(fc[i]);
      run_deal(i, ec, lat, err);
      compared++;
      if (lat !== 2 || dut_slot(i) !== model_hand[i]) begin
        mismatched++;
        $display("[TB] FAIL force_slot%0d: got %0d latency %0d expected %0d latency 2", i, dut_slot(i), lat, model_hand[i]);
      end
    end
    force_en = 1'b0;
    compared++;
    if (pscore !== 4'd6 || dscore !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL force_scores: got p=%0d d=%0d expected 6/0", pscore, dscore);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_counter();
    test_random_deals();
    test_illegal_slot();
    test_clear_hands();
    test_back_to_back();
    test_async_reset();
`ifdef DEAL_FORCE_EN
    test_force();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
